// File: rtl/stencil_feeder.sv
// stencil_feeder: upstream stage of the per-point calculation core.
//
// Accepts one radial sweep of N_POINTS grid samples as a valid/ready stream,
// keeps a 5-deep window per field and issues one stencil window per interior
// point (i = 2 .. N_POINTS-3) to the core. Each issue is a single-cycle
// core_start. The next window is filled only after a rising edge of
// core_finish. The two boundary points at each end are never issued.
//
// Handshake: a sample transfers on a rising clk edge where
// in_valid & in_ready are both high. in_ready is high only in FILL and never
// depends combinationally on in_valid. The upstream holds its data stable
// while in_valid is high and in_ready is low.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   sweep_start                 pulse, begins a sweep (honoured only in IDLE)
//   in_valid / in_ready         sample stream handshake
//   in_alpha .. in_r            sample fields, DW bits each
//   alpha*/phi*/psi* windows    isub_2 = oldest .. iadd_2 = newest sample
//   r_i, K_i, pi_m_i            centre-point values
//   core_start / core_finish    one-cycle start to core / finish level from core
//   centre_idx                  grid index of the issued centre point
//   busy                        high in every state except IDLE
//   sweep_done                  one-cycle pulse when all windows completed
//   timeout_err                 sticky, core did not finish within TIMEOUT cycles
//   dbg_state                   current FSM state (IDLE=0 FILL=1 ISSUE=2 WAIT=3 DONE=4)
module stencil_feeder #(
    parameter int DW       = 64,
    parameter int N_POINTS = 64,
    parameter int CW       = 16,
    parameter int TIMEOUT  = 1024
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sweep_start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_alpha,
    input  logic [DW-1:0] in_phi,
    input  logic [DW-1:0] in_psi,
    input  logic [DW-1:0] in_K,
    input  logic [DW-1:0] in_pi_m,
    input  logic [DW-1:0] in_r,
    output logic [DW-1:0] alphaisub_2,
    output logic [DW-1:0] alphaisub_1,
    output logic [DW-1:0] alpha_i,
    output logic [DW-1:0] alphaiadd_1,
    output logic [DW-1:0] alphaiadd_2,
    output logic [DW-1:0] phiisub_2,
    output logic [DW-1:0] phiisub_1,
    output logic [DW-1:0] phi_i,
    output logic [DW-1:0] phiiadd_1,
    output logic [DW-1:0] phiiadd_2,
    output logic [DW-1:0] psiisub_2,
    output logic [DW-1:0] psiisub_1,
    output logic [DW-1:0] psi_i,
    output logic [DW-1:0] psiiadd_1,
    output logic [DW-1:0] psiiadd_2,
    output logic [DW-1:0] r_i,
    output logic [DW-1:0] K_i,
    output logic [DW-1:0] pi_m_i,
    output logic          core_start,
    input  logic          core_finish,
    output logic [CW-1:0] centre_idx,
    output logic          busy,
    output logic          sweep_done,
    output logic          timeout_err,
    output logic [2:0]    dbg_state
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_OUT  = CW'(N_POINTS - 4);
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t        state_q;
    logic          in_ready_q;
    logic          core_start_q;
    logic          busy_q;
    logic          sweep_done_q;
    logic          timeout_err_q;
    logic          finish_q;
    logic [CW-1:0] in_cnt_q;
    logic [CW-1:0] out_cnt_q;
    logic [CW-1:0] centre_idx_q;
    logic [TW-1:0] timer_q;

    // Window registers: index 0 is the oldest sample (s0), 4 the newest (s4).
    // r/K/pi_m only need their centre value, so they keep s2..s4 (index 0 = s2).
    logic [DW-1:0] alpha_q [5];
    logic [DW-1:0] phi_q   [5];
    logic [DW-1:0] psi_q   [5];
    logic [DW-1:0] r_q     [3];
    logic [DW-1:0] k_q     [3];
    logic [DW-1:0] pi_m_q  [3];

    logic accept;
    logic fin_edge;

    assign accept   = in_valid & in_ready_q;
    // Only a rising edge counts, so a level left high from the previous
    // window cannot complete the current one.
    assign fin_edge = core_finish & ~finish_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            in_ready_q    <= 1'b0;
            core_start_q  <= 1'b0;
            busy_q        <= 1'b0;
            sweep_done_q  <= 1'b0;
            timeout_err_q <= 1'b0;
            finish_q      <= 1'b0;
            in_cnt_q      <= '0;
            out_cnt_q     <= '0;
            centre_idx_q  <= '0;
            timer_q       <= '0;
        end else begin
            finish_q <= core_finish;
            case (state_q)
                S_IDLE: begin
                    if (sweep_start) begin
                        state_q       <= S_FILL;
                        in_ready_q    <= 1'b1;
                        busy_q        <= 1'b1;
                        in_cnt_q      <= '0;
                        out_cnt_q     <= '0;
                        timeout_err_q <= 1'b0;
                        timer_q       <= '0;
                    end
                end
                S_FILL: begin
                    if (accept) begin
                        in_cnt_q <= in_cnt_q + CW'(1);
                        // Five beats complete the first window; afterwards
                        // every beat completes one.
                        if (in_cnt_q >= CW'(4)) begin
                            state_q      <= S_ISSUE;
                            in_ready_q   <= 1'b0;
                            core_start_q <= 1'b1;
                            centre_idx_q <= out_cnt_q + CW'(2);
                        end
                    end
                end
                S_ISSUE: begin
                    core_start_q <= 1'b0;
                    timer_q      <= '0;
                    state_q      <= S_WAIT;
                end
                S_WAIT: begin
                    // A finish edge in the same cycle as expiry still completes.
                    if (fin_edge) begin
                        out_cnt_q <= out_cnt_q + CW'(1);
                        timer_q   <= '0;
                        if (out_cnt_q + CW'(1) == LAST_OUT) begin
                            state_q      <= S_DONE;
                            sweep_done_q <= 1'b1;
                        end else begin
                            state_q    <= S_FILL;
                            in_ready_q <= 1'b1;
                        end
                    end else if (timer_q == TIMER_MAX) begin
                        timeout_err_q <= 1'b1;
                        timer_q       <= '0;
                        busy_q        <= 1'b0;
                        state_q       <= S_IDLE;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                S_DONE: begin
                    sweep_done_q <= 1'b0;
                    busy_q       <= 1'b0;
                    state_q      <= S_IDLE;
                end
                default: begin
                    state_q    <= S_IDLE;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < 5; j++) begin
                alpha_q[j] <= '0;
                phi_q[j]   <= '0;
                psi_q[j]   <= '0;
            end
            for (int j = 0; j < 3; j++) begin
                r_q[j]    <= '0;
                k_q[j]    <= '0;
                pi_m_q[j] <= '0;
            end
        end else if (accept) begin
            for (int j = 0; j < 4; j++) begin
                alpha_q[j] <= alpha_q[j+1];
                phi_q[j]   <= phi_q[j+1];
                psi_q[j]   <= psi_q[j+1];
            end
            alpha_q[4] <= in_alpha;
            phi_q[4]   <= in_phi;
            psi_q[4]   <= in_psi;
            for (int j = 0; j < 2; j++) begin
                r_q[j]    <= r_q[j+1];
                k_q[j]    <= k_q[j+1];
                pi_m_q[j] <= pi_m_q[j+1];
            end
            r_q[2]    <= in_r;
            k_q[2]    <= in_K;
            pi_m_q[2] <= in_pi_m;
        end
    end

    assign in_ready    = in_ready_q;
    assign core_start  = core_start_q;
    assign busy        = busy_q;
    assign sweep_done  = sweep_done_q;
    assign timeout_err = timeout_err_q;
    assign centre_idx  = centre_idx_q;
    assign dbg_state   = state_q;

    assign alphaisub_2 = alpha_q[0];
    assign alphaisub_1 = alpha_q[1];
    assign alpha_i     = alpha_q[2];
    assign alphaiadd_1 = alpha_q[3];
    assign alphaiadd_2 = alpha_q[4];
    assign phiisub_2   = phi_q[0];
    assign phiisub_1   = phi_q[1];
    assign phi_i       = phi_q[2];
    assign phiiadd_1   = phi_q[3];
    assign phiiadd_2   = phi_q[4];
    assign psiisub_2   = psi_q[0];
    assign psiisub_1   = psi_q[1];
    assign psi_i       = psi_q[2];
    assign psiiadd_1   = psi_q[3];
    assign psiiadd_2   = psi_q[4];
    assign r_i         = r_q[0];
    assign K_i         = k_q[0];
    assign pi_m_i      = pi_m_q[0];

endmodule

// File: doc/stencil_feeder.md
Name: stencil_feeder

Overview:
- Upstream stage of the per-point calculation core.
- Accepts one radial sweep of grid samples (alpha, phi, psi, K, pi_m, r) as a valid/ready stream.
- Builds the 5-point stencil window (i-2..i+2) and issues one window per interior point to the core with a single-cycle start, then waits for the core's finish before issuing the next.
- Boundary points (first two, last two) are not issued; ghost-cell handling belongs to a separate stage.

Parameters:
- DW, 64, data width of every sample.
- N_POINTS, 64, grid points per sweep; must be >= 5.
- CW, 16, width of point counters and centre_idx.
- TIMEOUT, 1024, max cycles in WAIT before abort.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- sweep_start  input  1  pulse; begins a sweep; honoured only in IDLE.
- in_valid  input  1  upstream sample valid.
- in_ready  output  1  sample accepted when in_valid & in_ready.
- in_alpha, in_phi, in_psi, in_K, in_pi_m, in_r  input  DW each  sample fields.
- alphaisub_2, alphaisub_1, alpha_i, alphaiadd_1, alphaiadd_2  output  DW each  alpha window.
- phiisub_2..phiiadd_2, psiisub_2..psiiadd_2  output  DW each  phi and psi windows, same ordering.
- r_i, K_i, pi_m_i  output  DW each  centre-point values.
- core_start  output  1  one-cycle start to core.
- core_finish  input  1  core finish level (AND of its valids).
- centre_idx  output  CW  grid index of the issued centre point.
- busy  output  1  high in every state except IDLE.
- sweep_done  output  1  one-cycle pulse at sweep end.
- timeout_err  output  1  sticky; cleared only by reset or the next accepted sweep_start.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; every output, window register, counter and finish_q is 0.
- Window storage: 5-entry shift register per field, s0..s4, s4 newest. On an accepted beat, s0<=s1 .. s3<=s4, s4<=new sample. Mapping: isub_2=s0, isub_1=s1, i=s2, iadd_1=s3, iadd_2=s4. r_i/K_i/pi_m_i are the s2 entries of their own shift registers. Outputs are driven directly from the registers and change only on accepted beats.
- Counters: in_cnt counts beats accepted this sweep; out_cnt counts windows completed. centre_idx = out_cnt + 2, registered, updated with core_start.
- Finish detection: finish_q <= core_finish every cycle in all states. fin_edge = core_finish & ~finish_q.
- IDLE: in_ready=0. sweep_start -> FILL; in_cnt, out_cnt, timeout_err and the wait timer clear.
- FILL: in_ready=1. An accept with pre-increment in_cnt >= 4 -> ISSUE. The first window therefore needs 5 beats; each later window needs 1 beat.
- ISSUE: exactly one cycle. core_start=1, in_ready=0 -> WAIT. Latency: core_start asserts the cycle after the completing beat is accepted.
- WAIT: in_ready=0; wait timer increments.
  - On fin_edge: out_cnt++, timer clears. If the new out_cnt == N_POINTS-4 -> DONE, otherwise -> FILL.
  - If the timer reaches TIMEOUT: timeout_err<=1 -> IDLE, with no sweep_done.
- DONE: sweep_done=1 for one cycle -> IDLE.
- Boundary conditions:
  - Beats offered beyond N_POINTS are never accepted: in_ready=0 outside FILL, and FILL is not re-entered after the last window.
  - fin_edge outside WAIT is ignored.
  - core_finish already high on WAIT entry (stale level) does not count; only a rising edge does.
  - fin_edge and TIMEOUT expiry in the same cycle: fin_edge wins.
  - sweep_start outside IDLE is ignored.
  - in_valid held with in_ready=0: no shift, no count.
  - Reset mid-sweep aborts immediately; no sweep_done; window returns to 0.

Test Plan:
- N_POINTS=8. After sweep_start, stream alpha=k, phi=10+k, psi=20+k, r=k for k=0..7, with in_valid held high and the core model returning a finish rising edge 3 cycles after each start.
  - Required: 4 core_start pulses.
  - Windows: alpha (0,1,2,3,4), (1,2,3,4,5), (2,3,4,5,6), (3,4,5,6,7); r_i=2,3,4,5.
  - centre_idx=2,3,4,5; exactly 8 beats accepted; one sweep_done pulse.
- Same sweep with in_valid toggling 1/0 every cycle -> identical windows and pulse count; no beat accepted while in_valid=0.
- core_finish held high from before the first start -> no completion counted until it falls and rises again; the next core_start follows that rising edge.
- TIMEOUT=16, core never finishes -> timeout_err=1 at cycle 16 of WAIT; state IDLE; sweep_done never pulses. A new sweep_start clears timeout_err.
- rst_n low during the third WAIT -> all outputs 0 asynchronously, busy=0. After release, a fresh sweep_start reproduces the first scenario exactly.
- sweep_start pulsed during FILL and during WAIT -> ignored; counts unchanged; in_ready=0 throughout ISSUE, WAIT and DONE.
